hitchhike_codeword_modulator: RTL and testbench

- Parametrised tag-side backscatter modulator for the 802.11b codeword-translation path.
- Detects a packet trigger and lets a programmable number of symbols (preamble/header) pass frequency-shifted only.
- Then embeds buffered tag data by phase-flipping the frequency-shift square wave for a programmable number of symbols per tag bit.
- Output drives the RF switch; it sits between the envelope-detect trigger and the switch driver.

---
 rtl/hitchhike_codeword_modulator.sv | 245 ++++++++++++++++++++++++
 tb/tb_hitchhike_codeword_modulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hitchhike_codeword_modulator.sv
// Tag-side backscatter modulator: frequency-shifts the 802.11b preamble/header
// and then phase-flips the shift wave to embed buffered tag bits.
module hitchhike_codeword_modulator #(
  parameter int unsigned SYMBOL_CYCLES = 10,
  parameter int unsigned SHIFT_HALF    = 2,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger_signal,
  input  logic [CNT_W-1:0]  skip_symbols,
  input  logic [1:0]        rate_sel,
  input  logic [CNT_W-1:0]  payload_words,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              signal_into_switch,
  output logic              data_path_signal,
  output logic              busy,
  output logic              done,
  output logic              underrun
);
  localparam int unsigned SYM_W  = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int unsigned HALF_W = (SHIFT_HALF > 1) ? $clog2(SHIFT_HALF) : 1;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned REP_W  = 3;

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_SEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q, sync3_q;
  logic              trig_edge;
  logic [CNT_W-1:0]  skip_q, skip_d, words_q, words_d;
  logic [CNT_W-1:0]  skip_cnt_q, skip_cnt_d, word_cnt_q, word_cnt_d;
  logic [1:0]        rate_q, rate_d;
  logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic              shift_sq_q, shift_sq_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              take, underrun_evt, want_send;
  logic              sym_last, rep_last, bit_last, skip_last, word_last;
  logic              data_ready_q, data_ready_d, sw_q, sw_d, dp_q, dp_d;
  logic              busy_q, busy_d, done_q, done_d, underrun_q, underrun_d;

  assign trig_edge = sync2_q & ~sync3_q;

  // Two-flop synchroniser plus one history flop for rising-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= trigger_signal;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // State register together with counters, buffers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      skip_q       <= '0;
      words_q      <= '0;
      rate_q       <= '0;
      skip_cnt_q   <= '0;
      word_cnt_q   <= '0;
      sym_cnt_q    <= '0;
      rep_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      half_cnt_q   <= '0;
      shift_sq_q   <= 1'b0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      data_ready_q <= 1'b1;
      sw_q         <= 1'b0;
      dp_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      words_q      <= words_d;
      rate_q       <= rate_d;
      skip_cnt_q   <= skip_cnt_d;
      word_cnt_q   <= word_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      half_cnt_q   <= half_cnt_d;
      shift_sq_q   <= shift_sq_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      data_ready_q <= data_ready_d;
      sw_q         <= sw_d;
      dp_q         <= dp_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
    end
  end

  // Next-state, symbol/bit/word timing, shift wave and word hand-off
  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    words_d      = words_q;
    rate_d       = rate_q;
    skip_cnt_d   = skip_cnt_q;
    word_cnt_d   = word_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    half_cnt_d   = half_cnt_q;
    shift_sq_d   = shift_sq_q;
    shreg_d      = shreg_q;
    take         = 1'b0;
    underrun_evt = 1'b0;
    want_send    = 1'b0;
    sym_last     = (sym_cnt_q == SYM_W'(SYMBOL_CYCLES - 1));
    rep_last     = (rep_cnt_q == REP_W'((32'd1 << rate_q) - 32'd1));
    bit_last     = (bit_cnt_q == BIT_W'(DATA_W - 1));
    skip_last    = (skip_cnt_q == skip_q - CNT_W'(1));
    word_last    = (word_cnt_q == words_q - CNT_W'(1));

    if (state_q == S_SKIP || state_q == S_SEND) begin
      if (half_cnt_q == HALF_W'(SHIFT_HALF - 1)) begin
        half_cnt_d = '0;
        shift_sq_d = ~shift_sq_q;
      end else begin
        half_cnt_d = half_cnt_q + HALF_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (trig_edge) begin
          skip_d     = skip_symbols;
          words_d    = payload_words;
          rate_d     = rate_sel;
          skip_cnt_d = '0;
          word_cnt_d = '0;
          sym_cnt_d  = '0;
          rep_cnt_d  = '0;
          bit_cnt_d  = '0;
          half_cnt_d = '0;
          shift_sq_d = 1'b0;
          if (payload_words == '0 && skip_symbols == '0) state_d = S_DONE;
          else if (skip_symbols == '0)                   want_send = 1'b1;
          else                                           state_d = S_SKIP;
        end
      end
      S_SKIP: begin
        if (sym_last) begin
          sym_cnt_d = '0;
          if (skip_last) begin
            if (words_q == '0) state_d = S_DONE;
            else               want_send = 1'b1;
          end else begin
            skip_cnt_d = skip_cnt_q + CNT_W'(1);
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SYM_W'(1);
        end
      end
      S_SEND: begin
        if (sym_last) begin
          sym_cnt_d = '0;
          if (rep_last) begin
            rep_cnt_d = '0;
            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
            if (bit_last) begin
              bit_cnt_d = '0;
              if (word_last) begin
                state_d = S_DONE;
              end else begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
                want_send  = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SYM_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A word boundary either pulls the next word or aborts on an empty holding register
    if (want_send) begin
      if (hold_valid_q) begin
        take    = 1'b1;
        shreg_d = hold_q;
        state_d = S_SEND;
      end else begin
        underrun_evt = 1'b1;
        state_d      = S_IDLE;
      end
    end
  end

  // Output decode and holding-register handshake
  always_comb begin
    busy_d       = (state_q == S_SKIP) || (state_q == S_SEND);
    done_d       = (state_q == S_DONE);
    underrun_d   = underrun_evt;
    dp_d         = 1'b0;
    sw_d         = 1'b0;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (state_q == S_SKIP) begin
      sw_d = shift_sq_q;
    end else if (state_q == S_SEND) begin
      dp_d = shreg_q[DATA_W-1];
      sw_d = shift_sq_q ^ shreg_q[DATA_W-1];
    end
    if (take) hold_valid_d = 1'b0;
    if (data_valid && data_ready_q) begin
      hold_valid_d = 1'b1;
      hold_d       = data_in;
    end
    data_ready_d = ~hold_valid_d;
  end

  assign data_ready         = data_ready_q;
  assign signal_into_switch = sw_q;
  assign data_path_signal   = dp_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign underrun           = underrun_q;

endmodule

// File: tb/tb_hitchhike_codeword_modulator.sv
// Self-checking bench: per-cycle comparison against a packet-timeline model.
module tb_hitchhike_codeword_modulator;
  localparam int SC = 10;
  localparam int SH = 2;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset, trigger_signal, data_valid;
  logic [CW-1:0] skip_symbols, payload_words;
  logic [1:0]    rate_sel;
  logic [DW-1:0] data_in;
  logic          data_ready, signal_into_switch, data_path_signal, busy, done, underrun;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] feed[$];
  logic [DW-1:0] m_data[$];
  int m_skip, m_rate, m_words;
  int rises;
  bit chk_ready;

  hitchhike_codeword_modulator #(
    .SYMBOL_CYCLES(SC), .SHIFT_HALF(SH), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .trigger_signal(trigger_signal),
    .skip_symbols(skip_symbols), .rate_sel(rate_sel), .payload_words(payload_words),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .signal_into_switch(signal_into_switch), .data_path_signal(data_path_signal),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // One clock; transfers the queued word when valid/ready met at that edge
  task automatic step();
    logic hs;
    hs = data_valid && data_ready;
    @(posedge clock);
    #1;
    if (hs && feed.size() > 0) void'(feed.pop_front());
    data_valid = (feed.size() > 0);
    if (feed.size() > 0) data_in = feed[0];
    else                 data_in = '0;
  endtask

  // Expected {busy, switch, datapath, done, underrun} n cycles after trigger acceptance
  function automatic logic [4:0] model(input int n);
    int wl, sk, fin, p, q, b, wd, bi, avail;
    bit full;
    logic w, d, be, se, de, dne, ue;
    logic [DW-1:0] word;
    avail = m_data.size();
    wl   = DW * (1 << m_rate) * SC;
    sk   = m_skip * SC;
    full = (avail >= m_words);
    fin  = full ? sk + m_words * wl : sk + avail * wl;
    be = 0; se = 0; de = 0; dne = 0;
    ue = !full && (n == fin + 1);
    p  = n - 2;
    if (p >= 0 && p < fin) begin
      be = 1;
      w  = ((p / SH) % 2) == 1;
      if (p < sk) begin
        se = w;
      end else begin
        q    = p - sk;
        b    = q / ((1 << m_rate) * SC);
        wd   = b / DW;
        bi   = b % DW;
        word = m_data[wd];
        d    = word[DW-1-bi];
        de   = d;
        se   = w ^ d;
      end
    end
    if (full && p == fin) dne = 1;
    return {be, se, de, dne, ue};
  endfunction

  function automatic int packet_end();
    int wl, sk;
    wl = DW * (1 << m_rate) * SC;
    sk = m_skip * SC;
    if (m_data.size() >= m_words) return sk + m_words * wl;
    return sk + m_data.size() * wl;
  endfunction

  task automatic check_cycle(input int n);
    logic [4:0] e;
    e = model(n);
    chk("busy",   n, 32'(busy),               32'(e[4]));
    chk("switch", n, 32'(signal_into_switch), 32'(e[3]));
    chk("dpath",  n, 32'(data_path_signal),   32'(e[2]));
    chk("done",   n, 32'(done),               32'(e[1]));
    chk("underr", n, 32'(underrun),           32'(e[0]));
  endtask

  task automatic preload(input int cnt);
    logic [DW-1:0] w;
    m_data = {};
    for (int i = 0; i < cnt; i++) begin
      w = DW'($urandom);
      m_data.push_back(w);
      feed.push_back(w);
    end
    repeat (3) step();
  endtask

  // Pulse the trigger and check every cycle of the packet against the model
  task automatic fire(input int skip, input int rate, input int words, input int retrig_n);
    int fin;
    logic prev;
    m_skip = skip; m_rate = rate; m_words = words;
    skip_symbols  = CW'(skip);
    rate_sel      = 2'(rate);
    payload_words = CW'(words);
    fin = packet_end();
    rises = 0;
    prev = data_ready;
    trigger_signal = 1'b1;
    step();
    trigger_signal = 1'b0;
    check_cycle(-1);
    for (int n = 0; n <= fin + 5; n++) begin
      step();
      check_cycle(n);
      if (data_ready && !prev) rises++;
      prev = data_ready;
      if (chk_ready && n == skip * SC)     chk("ready_pre",  n, 32'(data_ready), 32'd0);
      if (chk_ready && n == skip * SC + 1) chk("ready_take", n, 32'(data_ready), 32'd1);
      if (n == 1) begin
        skip_symbols  = CW'($urandom);
        rate_sel      = 2'($urandom);
        payload_words = CW'($urandom);
      end
      trigger_signal = (n == retrig_n);
    end
    repeat (3) step();
  endtask

  initial begin
    reset = 1'b1; trigger_signal = 1'b0; data_valid = 1'b0; data_in = '0;
    skip_symbols = '0; rate_sel = '0; payload_words = '0; chk_ready = 0;
    repeat (3) step();
    chk("rst_ready",  0, 32'(data_ready),         32'd1);
    chk("rst_busy",   0, 32'(busy),               32'd0);
    chk("rst_switch", 0, 32'(signal_into_switch), 32'd0);
    chk("rst_dpath",  0, 32'(data_path_signal),   32'd0);
    chk("rst_done",   0, 32'(done),               32'd0);
    chk("rst_underr", 0, 32'(underrun),           32'd0);
    reset = 1'b0;
    repeat (2) step();

    // Word 0xA5 after three skipped symbols at one symbol per bit
    m_data = {8'hA5};
    feed.push_back(8'hA5);
    repeat (3) step();
    chk("hold_full", 0, 32'(data_ready), 32'd0);
    fire(3, 0, 1, -10);

    // Slow rate: lone MSB inverted for four symbols
    m_data = {8'h80};
    feed.push_back(8'h80);
    repeat (3) step();
    fire(0, 2, 1, -10);

    // Two words requested, one supplied
    preload(1);
    fire(0, 0, 2, -10);

    // Empty packet with no skip goes straight to completion
    m_data = {};
    fire(0, 0, 0, -10);

    // Four back-to-back words with a stray trigger mid-SEND
    preload(4);
    chk_ready = 1;
    fire(1, 0, 4, 150);
    chk_ready = 0;
    chk("ready_rises", 0, 32'(rises), 32'd4);

    // Randomised packets, some deliberately short of data
    for (int k = 0; k < 6; k++) begin
      int s, r, w, a;
      s = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 1));
      w = int'($urandom_range(1, 2));
      a = (k % 3 == 2) ? w - 1 : w;
      preload(a);
      fire(s, r, w, -10);
    end

    // Reset in the middle of SKIP
    preload(1);
    skip_symbols = CW'(3); rate_sel = 2'd0; payload_words = CW'(1);
    trigger_signal = 1'b1;
    step();
    trigger_signal = 1'b0;
    repeat (8) step();
    chk("skip_busy", 0, 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    chk("mrst_ready",  0, 32'(data_ready),         32'd1);
    chk("mrst_busy",   0, 32'(busy),               32'd0);
    chk("mrst_switch", 0, 32'(signal_into_switch), 32'd0);
    chk("mrst_dpath",  0, 32'(data_path_signal),   32'd0);
    chk("mrst_done",   0, 32'(done),               32'd0);
    chk("mrst_underr", 0, 32'(underrun),           32'd0);
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      chk("post_rst_quiet", n, 32'({busy, done, underrun, signal_into_switch}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
